// File: rtl/fullconnect_write_buffer.sv
// Packs narrow FullConnect results into Avalon-width words and queues them
// in a small circular FIFO for the write master's req/ack handshake.
module fullconnect_write_buffer #(
  parameter int ResultWidth      = 32,
  parameter int AvalonData_WIDTH = 512,
  parameter int FifoDepth        = 4
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          Clear_i,
  input  logic [ResultWidth-1:0]        ResultData_i,
  input  logic                          ResultValid_i,
  input  logic                          ResultLast_i,
  output logic                          ResultReady_o,
  output logic [AvalonData_WIDTH-1:0]   WriteData_o,
  output logic                          WriteReq_o,
  input  logic                          WriteAck_i,
  output logic [8:0]                    WordCount_o,
  output logic [$clog2(FifoDepth):0]    Level_o
);

  localparam int Lanes = AvalonData_WIDTH / ResultWidth;
  localparam int LaneW = (Lanes > 1) ? $clog2(Lanes) : 1;
  localparam int PtrW  = $clog2(FifoDepth);
  localparam logic [PtrW:0]    FullLevel = (PtrW+1)'(FifoDepth);
  localparam logic [LaneW-1:0] LastLane  = LaneW'(Lanes - 1);

  logic [LaneW-1:0]            lane;
  logic [AvalonData_WIDTH-1:0] pack;
  logic [AvalonData_WIDTH-1:0] packed_word;
  logic [AvalonData_WIDTH-1:0] mem [FifoDepth];
  logic [PtrW-1:0]             wr_ptr;
  logic [PtrW-1:0]             rd_ptr;
  logic [PtrW:0]               level;
  logic [8:0]                  count;
  logic                        full;
  logic                        accept;
  logic                        push;
  logic                        pop;

  assign full   = (level == FullLevel);
  assign accept = ResultValid_i & ~full;
  assign push   = accept & ((lane == LastLane) | ResultLast_i);
  assign pop    = (level != '0) & WriteAck_i;

  // Lanes above the current one are always zero in pack, so a Last push
  // naturally zero-fills the upper part of the word.
  always_comb begin
    packed_word = pack;
    packed_word[lane*ResultWidth +: ResultWidth] = ResultData_i;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      lane <= '0;
      pack <= '0;
    end else if (Clear_i) begin
      lane <= '0;
      pack <= '0;
    end else if (push) begin
      lane <= '0;
      pack <= '0;
    end else if (accept) begin
      lane <= lane + 1'b1;
      pack <= packed_word;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !Clear_i) begin
      mem[wr_ptr] <= packed_word;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      count  <= '0;
    end else if (Clear_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
        count  <= count + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  assign ResultReady_o = ~full;
  assign WriteReq_o    = (level != '0);
  assign WriteData_o   = (level != '0) ? mem[rd_ptr] : '0;
  assign WordCount_o   = count;
  assign Level_o       = level;

endmodule

// File: tb/tb_fullconnect_write_buffer.sv
// Self-checking bench: a queue-based reference model checked every cycle,
// plus hand-computed literal expectations for the key scenarios.
module tb_fullconnect_write_buffer;

  logic         clk;
  logic         rstn;
  logic         clear;
  logic [31:0]  result_data;
  logic         result_valid;
  logic         result_last;
  logic         result_ready;
  logic [511:0] write_data;
  logic         write_req;
  logic         write_ack;
  logic [8:0]   word_count;
  logic [2:0]   level;

  int errors = 0;
  int checks = 0;

  fullconnect_write_buffer #(
    .ResultWidth(32),
    .AvalonData_WIDTH(512),
    .FifoDepth(4)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .Clear_i(clear),
    .ResultData_i(result_data),
    .ResultValid_i(result_valid),
    .ResultLast_i(result_last),
    .ResultReady_o(result_ready),
    .WriteData_o(write_data),
    .WriteReq_o(write_req),
    .WriteAck_i(write_ack),
    .WordCount_o(word_count),
    .Level_o(level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: completed words in a queue, partial word as lane array.
  logic [511:0] mq[$];
  logic [31:0]  part[16];
  int           m_lanes;
  int           m_count;
  bit           m_acc;
  bit           m_pop;
  logic [511:0] m_word;

  always @(posedge clk or negedge rstn) begin
    if (!rstn || clear) begin
      mq.delete();
      m_lanes = 0;
      m_count = 0;
    end else begin
      m_acc = result_valid && (mq.size() < 4);
      m_pop = (mq.size() != 0) && write_ack;
      if (m_pop) void'(mq.pop_front());
      if (m_acc) begin
        part[m_lanes] = result_data;
        m_lanes++;
        if (m_lanes == 16 || result_last) begin
          m_word = '0;
          for (int k = 0; k < m_lanes; k++) m_word[k*32 +: 32] = part[k];
          mq.push_back(m_word);
          m_count = (m_count + 1) % 512;
          m_lanes = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    check("ready", 512'(result_ready), 512'(mq.size() < 4));
    check("req",   512'(write_req),    512'(mq.size() != 0));
    check("data",  write_data,         (mq.size() != 0) ? mq[0] : 512'h0);
    check("count", 512'(word_count),   512'(m_count));
    check("level", 512'(level),        512'(mq.size()));
  end

  task automatic send(input logic [31:0] d, input logic last);
    int   waited;
    logic acc;
    waited       = 0;
    acc          = 1'b0;
    result_data  = d;
    result_last  = last;
    result_valid = 1'b1;
    while (!acc) begin
      @(negedge clk);
      acc = result_ready;
      @(posedge clk);
      #2;
      if (!acc) begin
        waited++;
        if (waited > 100) begin
          checks++;
          errors++;
          $display("[TB] FAIL send_timeout: got ready=0 expected accept within 100 cycles");
          break;
        end
      end
    end
    result_valid = 1'b0;
    result_last  = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    cycles(1);
    clear = 1'b0;
  endtask

  initial begin
    rstn = 1'b0; clear = 1'b0; result_data = '0; result_valid = 1'b0;
    result_last = 1'b0; write_ack = 1'b0;
    cycles(2);
    check("reset_ready", 512'(result_ready), 512'd1);
    check("reset_req",   512'(write_req),    512'd0);
    check("reset_data",  write_data,         512'h0);
    rstn = 1'b1;
    cycles(1);

    // Single full word, lane k = k
    write_ack = 1'b1;
    for (int i = 0; i < 16; i++) send(32'(i), 1'b0);
    check("full_word_req", 512'(write_req), 512'd1);
    check("full_word_data", write_data,
          512'h0000000F_0000000E_0000000D_0000000C_0000000B_0000000A_00000009_00000008_00000007_00000006_00000005_00000004_00000003_00000002_00000001_00000000);
    check("full_word_count", 512'(word_count), 512'd1);
    cycles(1);
    check("full_word_req_drop", 512'(write_req), 512'd0);

    // Partial word closed by Last
    send(32'hA, 1'b0); send(32'hB, 1'b0); send(32'hC, 1'b1);
    check("partial_data", write_data, {416'h0, 32'hC, 32'hB, 32'hA});
    check("partial_count", 512'(word_count), 512'd2);
    cycles(2);

    // Backpressure: 64 results with ack held low
    write_ack = 1'b0;
    for (int i = 0; i < 64; i++) send(32'(100 + i), 1'b0);
    check("bp_level", 512'(level), 512'd4);
    check("bp_ready", 512'(result_ready), 512'd0);
    result_data = 32'd999; result_last = 1'b1; result_valid = 1'b1;
    cycles(5);
    check("bp_held_level", 512'(level), 512'd4);
    check("bp_head_lane0", 512'(write_data[31:0]), 512'd100);
    write_ack = 1'b1;
    send(32'd999, 1'b1);
    cycles(10);

    // Idle ack must not pop an empty FIFO
    cycles(10);
    check("idle_level", 512'(level), 512'd0);
    for (int i = 0; i < 16; i++) send(32'(300 + i), 1'b0);
    cycles(3);
    check("idle_count", 512'(word_count), 512'd8);

    // Simultaneous push/pop at level 2 across 600 words
    pulse_clear();
    check("clear_count", 512'(word_count), 512'd0);
    write_ack = 1'b0;
    for (int i = 0; i < 32; i++) send(32'(1000 + i), 1'b0);
    for (int w = 0; w < 598; w++) begin
      for (int l = 0; l < 16; l++) begin
        write_ack = (l == 15);
        send(32'(w * 16 + l), 1'b0);
      end
      write_ack = 1'b0;
    end
    check("pp_level", 512'(level), 512'd2);
    check("pp_count", 512'(word_count), 512'd88);
    write_ack = 1'b1;
    cycles(5);

    // Clear mid-word with two words queued
    write_ack = 1'b0;
    for (int i = 0; i < 37; i++) send(32'(i), 1'b0);
    pulse_clear();
    check("clr_level", 512'(level), 512'd0);
    check("clr_req",   512'(write_req), 512'd0);
    check("clr_count", 512'(word_count), 512'd0);
    check("clr_data",  write_data, 512'h0);
    write_ack = 1'b1;
    for (int i = 0; i < 16; i++) send(32'(32'h200 + i), 1'b0);
    check("clr_word_lane15", 512'(write_data[511:480]), 512'h20F);
    cycles(3);

    // Same sequence with an asynchronous reset pulse
    write_ack = 1'b0;
    for (int i = 0; i < 37; i++) send(32'(i), 1'b0);
    #1 rstn = 1'b0;
    #1;
    check("rst_level", 512'(level), 512'd0);
    check("rst_req",   512'(write_req), 512'd0);
    check("rst_count", 512'(word_count), 512'd0);
    check("rst_ready", 512'(result_ready), 512'd1);
    cycles(1);
    rstn = 1'b1;
    write_ack = 1'b1;
    for (int i = 0; i < 16; i++) send(32'(32'h300 + i), 1'b0);
    check("rst_word_lane0", 512'(write_data[31:0]), 512'h300);
    cycles(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fullconnect_write_buffer.md
# fullconnect_write_buffer

Packs narrow FullConnect result values from the compute core into full-width Avalon words and buffers them in a small FIFO. It presents those words to the core write master over a request/acknowledge handshake. The block sits directly upstream of the write master: its `WriteData_o`/`WriteReq_o` drive the master's `WriteData_i`/`WriteReq_i`, and the master's `WriteAck_o` returns to it as `WriteAck_i`.

## Interface
- `ResultWidth`, default 32: width of one result value.
- `AvalonData_WIDTH`, default 512: packed word width; must be an integer multiple of `ResultWidth`. Lanes = `AvalonData_WIDTH`/`ResultWidth` (16 by default).
- `FifoDepth`, default 4: number of word entries, power of two, ≥ 2.

Ports:
- `clk` in 1: single clock; all state on its rising edge.
- `rstn` in 1: reset, asynchronous, active-low.
- `Clear_i` in 1: synchronous clear of packer, FIFO and counters.
- `ResultData_i` in `ResultWidth`: result value.
- `ResultValid_i` in 1: result present.
- `ResultLast_i` in 1: final result of the layer; qualified by `ResultValid_i`.
- `ResultReady_o` out 1: block can accept a result this cycle.
- `WriteData_o` out `AvalonData_WIDTH`: FIFO head word.
- `WriteReq_o` out 1: head word valid.
- `WriteAck_i` in 1: master accepted the head word; meaningful only while `WriteReq_o`=1.
- `WordCount_o` out 9: number of words pushed since reset or clear, wraps mod 512.
- `Level_o` out log2(`FifoDepth`)+1: FIFO occupancy.

## Operation
- A result is accepted on a cycle with `ResultValid_i` & `ResultReady_o`.
- `ResultReady_o` = ~full, where full means `Level_o` == `FifoDepth`.
- **Packer:**
  - Lane counter 0..Lanes-1.
  - An accepted result is written to bits [k·ResultWidth +: ResultWidth], where k = lane counter. Lane 0 is the LSBs.
- **Push:** a word is pushed into the FIFO when the accepted result is in lane Lanes-1, or when `ResultLast_i`=1.
  - The pushed word contains the new lane plus all earlier lanes of this word.
  - On a `ResultLast_i` push, lanes above k are zero.
  - After a push, the lane counter and packing register reset to 0.
- **Pop:** occurs on a cycle with `WriteReq_o` & `WriteAck_i`.
  - `WriteAck_i` while `WriteReq_o`=0 is ignored. The master drives ack=1 when idle; this must not pop.
- **FIFO:**
  - Circular buffer with read/write pointers of log2(`FifoDepth`) bits, wrapping naturally.
  - `Level_o` updates each cycle: +1 on push only, −1 on pop only, unchanged on simultaneous push and pop.
- **Outputs:**
  - `WriteReq_o` = (`Level_o` ≠ 0).
  - `WriteData_o` = head entry when non-empty, all zeros when empty.
  - The head stays stable until popped.
- `WordCount_o` increments by 1 on every push.
- **`Clear_i`** empties the FIFO, zeros the packer, lane counter and `WordCount_o`, and discards any same-cycle push or pop. It takes priority over all other activity.
- No state machine beyond the lane counter and FIFO; no data is ever dropped except on `Clear_i` or reset.

## Timing
- **Reset values:**
  - `ResultReady_o`=1, `WriteReq_o`=0, `WriteData_o`=0.
  - `WordCount_o`=0, `Level_o`=0.
  - Lane counter 0, pointers 0.
- **Latency:** a word whose final lane is accepted at edge N has `WriteReq_o`=1 and valid `WriteData_o` from edge N, i.e. visible in cycle N+1. There is no combinational path from `ResultValid_i` to `WriteReq_o`.
- `ResultReady_o` depends only on registered `Level_o`; there is no combinational path from `WriteAck_i`. A pop in cycle N makes ready high from cycle N+1.
- `WriteReq_o` drops in the cycle after the last entry is popped, unless a push occurred on the same edge.
- **Full with push pending:** the result is held off (ready=0). A pop restores ready on the next cycle.
- **Reset mid-operation:** asserting `rstn` low immediately forces the reset values. A partial word and any queued words are lost.

## Test plan
- **Single full word:** reset, then 16 results valued 0..15 with ack=1.
  - One word; lane k = k.
  - `WriteReq_o` high for one cycle starting the cycle after the 16th acceptance.
  - `WordCount_o`=1.
- **Partial word on Last:** results 0xA, 0xB, 0xC, with Last on 0xC.
  - Word = lanes {0xA, 0xB, 0xC}, upper 13 lanes zero.
  - Lane counter then 0.
- **Backpressure from master:** ack held 0 while 64 results are sent.
  - `Level_o` reaches 4 and `ResultReady_o` falls after the 64th acceptance.
  - A 65th result is held off.
  - Releasing ack drains the FIFO in order: word 0 first, data stable while waiting.
- **Idle ack:** ack=1 with the FIFO empty for 10 cycles.
  - `Level_o` stays 0 and no pop occurs.
  - A subsequent word is still delivered.
- **Simultaneous push/pop at `Level_o`=2:** `Level_o` stays 2, order is preserved, and pointers wrap correctly after 600 words.
  - `WordCount_o` wraps to 88.
- **Clear and reset mid-word:**
  - Clear after 5 results with 2 words queued: all counters and outputs 0 next cycle, and the next 16 results form a clean word.
  - The same sequence with `rstn` pulsed low gives the same result asynchronously.
